// File: rtl/row_fifo_sched.sv
// row_fifo_sched: waits until every row FIFO holds data, then pops one word from
// each row together and writes the words one per cycle into the downstream FIFO,
// starting with row ROW-1. It counts groups per frame and pulses o_done when the
// frame is complete.
module row_fifo_sched #(
  parameter int unsigned ROW       = 3,
  parameter int unsigned DW        = 9,
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic [ROW-1:0]                 i_fifo_empty,
  input  logic [DW*ROW-1:0]              i_fifo_data,
  output logic [ROW-1:0]                 o_fifo_rden,
  input  logic                           i_out_full,
  output logic [DW-1:0]                  o_out_data,
  output logic                           o_out_wren,
  output logic [$clog2(ROW)-1:0]         o_sel,
  output logic [$clog2(FRAME_LEN+1)-1:0] o_group_cnt,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int unsigned SEL_W = $clog2(ROW);
  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_POP  = 3'd2,
    S_CAPT = 3'd3,
    S_EMIT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [DW*ROW-1:0]     r_shadow;
  logic [SEL_W-1:0]      r_slot;
  logic [ROW-1:0]        r_rden;
  logic [DW-1:0]         r_out_data;
  logic                  r_out_wren;
  logic [SEL_W-1:0]      r_sel;
  logic [CNT_W-1:0]      r_group_cnt;
  logic                  r_busy;
  logic                  r_done;

  logic [DW*ROW-1:0]     w_shadow_nxt;
  logic [SEL_W-1:0]      w_slot_nxt;
  logic [ROW-1:0]        w_rden_nxt;
  logic [DW-1:0]         w_out_data_nxt;
  logic                  w_out_wren_nxt;
  logic [SEL_W-1:0]      w_sel_nxt;
  logic [CNT_W-1:0]      w_group_cnt_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;

  logic [DW-1:0]         w_rows [ROW];
  logic [SEL_W-1:0]      w_row_idx;
  logic [DW-1:0]         w_emit_word;
  logic                  w_all_ready;
  logic                  w_write;
  logic                  w_last_slot;
  logic [CNT_W-1:0]      w_group_inc;
  logic                  w_frame_end;

  // Unpack the shadow register and select the row for the current slot (slot 0 = row ROW-1)
  always_comb begin
    for (int i = 0; i < int'(ROW); i++) begin
      w_rows[i] = r_shadow[i*DW +: DW];
    end
    w_row_idx   = SEL_W'(ROW - 1) - r_slot;
    w_emit_word = w_rows[w_row_idx];
  end

  assign w_all_ready = (i_fifo_empty == '0);
  assign w_write     = (r_state == S_EMIT) && !i_out_full;
  assign w_last_slot = (r_slot == SEL_W'(ROW - 1));
  assign w_group_inc = r_group_cnt + CNT_W'(1);
  assign w_frame_end = (w_group_inc == CNT_W'(FRAME_LEN));

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_ARM;
      S_ARM:  if (w_all_ready) w_state_nxt = S_POP;
      S_POP:  w_state_nxt = S_CAPT;
      S_CAPT: w_state_nxt = S_EMIT;
      S_EMIT: if (w_write && w_last_slot) w_state_nxt = w_frame_end ? S_DONE : S_ARM;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    w_shadow_nxt    = r_shadow;
    w_slot_nxt      = r_slot;
    w_rden_nxt      = '0;
    w_out_data_nxt  = r_out_data;
    w_out_wren_nxt  = 1'b0;
    w_sel_nxt       = r_sel;
    w_group_cnt_nxt = r_group_cnt;
    w_done_nxt      = 1'b0;
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    case (r_state)
      S_IDLE: if (i_start) w_group_cnt_nxt = '0;
      S_ARM:  if (w_all_ready) w_rden_nxt = '1;
      S_CAPT: begin
        w_shadow_nxt = i_fifo_data;
        w_slot_nxt   = '0;
      end
      S_EMIT: begin
        if (w_write) begin
          w_out_data_nxt = w_emit_word;
          w_sel_nxt      = r_slot;
          w_out_wren_nxt = 1'b1;
          w_slot_nxt     = w_last_slot ? '0 : r_slot + SEL_W'(1);
          if (w_last_slot) w_group_cnt_nxt = w_group_inc;
        end
      end
      S_DONE: w_done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow    <= '0;
      r_slot      <= '0;
      r_rden      <= '0;
      r_out_data  <= '0;
      r_out_wren  <= 1'b0;
      r_sel       <= '0;
      r_group_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_shadow    <= w_shadow_nxt;
      r_slot      <= w_slot_nxt;
      r_rden      <= w_rden_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_wren  <= w_out_wren_nxt;
      r_sel       <= w_sel_nxt;
      r_group_cnt <= w_group_cnt_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign o_fifo_rden = r_rden;
  assign o_out_data  = r_out_data;
  assign o_out_wren  = r_out_wren;
  assign o_sel       = r_sel;
  assign o_group_cnt = r_group_cnt;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_row_fifo_sched.sv
// Testbench for row_fifo_sched: a row-FIFO model feeds the DUT, a scoreboard
// holds the expected downstream writes and a negedge monitor checks them.
module tb_row_fifo_sched;

  localparam int unsigned ROW       = 3;
  localparam int unsigned DW        = 9;
  localparam int unsigned FRAME_LEN = 2;
  localparam int unsigned SEL_W     = $clog2(ROW);
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int unsigned ALL_W     = ROW + DW + 1 + SEL_W + CNT_W + 2;

  logic                  clk = 1'b0;
  logic                  i_rst_n;
  logic                  i_start;
  logic [ROW-1:0]        i_fifo_empty = '1;
  logic [DW*ROW-1:0]     i_fifo_data  = '0;
  logic [ROW-1:0]        o_fifo_rden;
  logic                  i_out_full;
  logic [DW-1:0]         o_out_data;
  logic                  o_out_wren;
  logic [SEL_W-1:0]      o_sel;
  logic [CNT_W-1:0]      o_group_cnt;
  logic                  o_busy;
  logic                  o_done;
  logic [ALL_W-1:0]      w_all;

  typedef struct packed {
    logic [DW-1:0]    data;
    logic [SEL_W-1:0] sel;
    logic [CNT_W-1:0] grp;
  } exp_t;

  exp_t             sb[$];
  logic [DW-1:0]    q0[$];
  logic [DW-1:0]    q1[$];
  logic [DW-1:0]    q2[$];
  logic [ROW-1:0]   push_req;
  logic [DW-1:0]    push_val [ROW];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_cnt   = 0;

  always #5 clk = ~clk;

  row_fifo_sched #(.ROW(ROW), .DW(DW), .FRAME_LEN(FRAME_LEN)) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_data  (i_fifo_data),
    .o_fifo_rden  (o_fifo_rden),
    .i_out_full   (i_out_full),
    .o_out_data   (o_out_data),
    .o_out_wren   (o_out_wren),
    .o_sel        (o_sel),
    .o_group_cnt  (o_group_cnt),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  assign w_all = {o_fifo_rden, o_out_data, o_out_wren, o_sel, o_group_cnt, o_busy, o_done};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Row FIFO model: pushes requested by the bench, pops on rden, data valid next cycle
  always @(posedge clk) begin : fifo_model
    logic [DW-1:0] d0, d1, d2;
    if (push_req[0]) q0.push_back(push_val[0]);
    if (push_req[1]) q1.push_back(push_val[1]);
    if (push_req[2]) q2.push_back(push_val[2]);
    if (o_fifo_rden != '0) begin
      d0 = '0; d1 = '0; d2 = '0;
      if (o_fifo_rden[0] && q0.size() != 0) d0 = q0.pop_front();
      if (o_fifo_rden[1] && q1.size() != 0) d1 = q1.pop_front();
      if (o_fifo_rden[2] && q2.size() != 0) d2 = q2.pop_front();
      i_fifo_data <= {d2, d1, d0};
    end
    i_fifo_empty <= {q2.size() == 0, q1.size() == 0, q0.size() == 0};
  end

  // Monitor: every downstream write must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (o_out_wren) begin
      wr_cnt++;
      check("wr_expected", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("wr_data", 32'(o_out_data), 32'(e.data));
        check("wr_sel",  32'(o_sel),      32'(e.sel));
        check("wr_grp",  32'(o_group_cnt), 32'(e.grp));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    cyc++;
    push_req = '0;
    i_start  = 1'b0;
  endtask

  // Queue one word in each row and the three writes it must produce (row 2 first)
  task automatic push_group(input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                            input logic [DW-1:0] v2, input int grp);
    push_req    = '1;
    push_val[0] = v0;
    push_val[1] = v1;
    push_val[2] = v2;
    sb.push_back('{data: v2, sel: SEL_W'(0), grp: CNT_W'(grp - 1)});
    sb.push_back('{data: v1, sel: SEL_W'(1), grp: CNT_W'(grp - 1)});
    sb.push_back('{data: v0, sel: SEL_W'(2), grp: CNT_W'(grp)});
  endtask

  // Wait for o_done; it must follow a write and last exactly one cycle
  task automatic wait_done(input string tag, output int dcyc);
    logic prev_wren;
    logic found;
    found     = 1'b0;
    prev_wren = o_out_wren;
    dcyc      = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (o_done) begin
        found = 1'b1;
        dcyc  = cyc;
        break;
      end
      prev_wren = o_out_wren;
    end
    check({tag, "_done_seen"}, 32'(found), 32'(1));
    check({tag, "_done_after_last_wren"}, 32'(prev_wren), 32'(1));
    check({tag, "_wren_low_at_done"}, 32'(o_out_wren), 32'(0));
    check({tag, "_grp_at_done"}, 32'(o_group_cnt), 32'(FRAME_LEN));
    step();
    check({tag, "_done_one_cycle"}, 32'(o_done), 32'(0));
    check({tag, "_idle_after_done"}, 32'(o_busy), 32'(0));
    check({tag, "_grp_holds"}, 32'(o_group_cnt), 32'(FRAME_LEN));
  endtask

  initial begin
    int   dcyc;
    int   c0;
    int   w0;
    logic found;
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_out_full = 1'b0;
    push_req   = '0;
    for (int r = 0; r < int'(ROW); r++) push_val[r] = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", 32'(w_all), 32'(0));
    i_rst_n = 1'b1;

    // Idle with data available and no start
    push_group(9'h001, 9'h002, 9'h003, 1);
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_outs", 32'(w_all), 32'(0));
    end

    // Single group: pop timing and emission order
    i_start = 1'b1;
    step();
    check("t2_busy", 32'(o_busy), 32'(1));
    check("t2_rden_low_in_arm", 32'(o_fifo_rden), 32'(0));
    step();
    check("t2_rden", 32'(o_fifo_rden), 32'(3'b111));
    step();
    check("t2_rden_one_cycle", 32'(o_fifo_rden), 32'(0));
    step();
    check("t2_no_wren_capt", 32'(o_out_wren), 32'(0));
    step();
    check("t2_first_wren", 32'(o_out_wren), 32'(1));
    step();
    step();
    check("t2_grp_after_third", 32'(o_group_cnt), 32'(1));

    // Row 1 empty: no pop while any row is empty
    push_req    = 3'b101;
    push_val[0] = 9'h011;
    push_val[2] = 9'h033;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t3_no_rden_partial", 32'(o_fifo_rden), 32'(0));
    end
    push_req    = 3'b010;
    push_val[1] = 9'h022;
    sb.push_back('{data: 9'h033, sel: SEL_W'(0), grp: CNT_W'(1)});
    sb.push_back('{data: 9'h022, sel: SEL_W'(1), grp: CNT_W'(1)});
    sb.push_back('{data: 9'h011, sel: SEL_W'(2), grp: CNT_W'(2)});
    step();
    check("t3_rows_nonempty", 32'(i_fifo_empty), 32'(0));
    check("t3_rden_not_yet", 32'(o_fifo_rden), 32'(0));
    step();
    check("t3_rden_after_nonempty", 32'(o_fifo_rden), 32'(3'b111));
    wait_done("fa", dcyc);

    // Back-pressure: 4 full cycles after the first word
    push_group(9'h001, 9'h002, 9'h003, 1);
    step();
    push_group(9'h0AA, 9'h0BB, 9'h0CC, 2);
    step();
    i_start = 1'b1;
    step();
    step();
    check("t4_rden", 32'(o_fifo_rden), 32'(3'b111));
    c0 = cyc;
    step();
    step();
    step();
    check("t4_first_wren", 32'(o_out_wren), 32'(1));
    i_out_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_wren_held", 32'(o_out_wren), 32'(0));
      check("t4_data_hold", 32'(o_out_data), 32'(9'h003));
      check("t4_sel_hold", 32'(o_sel), 32'(0));
    end
    i_out_full = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_fifo_rden == 3'b111) begin
        found = 1'b1;
        break;
      end
    end
    check("t4_second_rden_seen", 32'(found), 32'(1));
    check("t4_group_period", 32'(cyc - c0), 32'(10));
    wait_done("fb", dcyc);

    // Full frame with data always available; a mid-frame start is ignored
    push_group(9'h101, 9'h102, 9'h103, 1);
    step();
    push_group(9'h104, 9'h105, 9'h106, 2);
    step();
    w0      = wr_cnt;
    i_start = 1'b1;
    c0      = cyc;
    step();
    step();
    step();
    i_start = 1'b1;
    step();
    wait_done("fc", dcyc);
    check("t5_frame_cycles", 32'(dcyc - c0), 32'(FRAME_LEN * (ROW + 3) + 2));
    check("t5_write_count", 32'(wr_cnt - w0), 32'(FRAME_LEN * ROW));
    for (int i = 0; i < 10; i++) begin
      step();
      check("t5_no_second_frame", 32'({o_busy, o_fifo_rden}), 32'(0));
    end

    // Reset after the second write of a group
    push_group(9'h1F1, 9'h1F2, 9'h1F3, 1);
    step();
    i_start = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("t6_second_wren", 32'(o_out_wren), 32'(1));
    check("t6_second_sel", 32'(o_sel), 32'(1));
    #1;
    i_rst_n = 1'b0;
    #1;
    check("t6_async_reset_outs", 32'(w_all), 32'(0));
    sb.delete();
    step();
    step();
    i_rst_n = 1'b1;
    step();
    check("t6_idle_after_reset", 32'(w_all), 32'(0));
    push_group(9'h055, 9'h066, 9'h077, 1);
    step();
    push_group(9'h088, 9'h099, 9'h0EE, 2);
    step();
    i_start = 1'b1;
    step();
    check("t6_restart_busy", 32'(o_busy), 32'(1));
    check("t6_restart_grp", 32'(o_group_cnt), 32'(0));
    step();
    check("t6_fresh_pop", 32'(o_fifo_rden), 32'(3'b111));
    wait_done("fd", dcyc);

    repeat (3) step();
    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
